vlb_chn_join: RTL and testbench

- Joins `N` VLB requester channels onto one shared translation-table-walk (TTW) port of the VLB/TTW complex; the ilb and dlb sides each instantiate one.
- Routes the shared TTW response and busy to the owning channel, selected by the top index bits.
- Merges per-channel kill requests: bit 0 is an immediate OR; the flush kill is a barrier that fires only when every enabled channel has asked.
- Provides a barrier watchdog that forces a stalled flush, plus registered request valid/index per channel.

---
 rtl/vlb_chn_join_pkg.sv | 26 ++
 rtl/vlb_chn_join_if.sv | 44 ++++
 rtl/vlb_kill_barrier.sv | 85 ++++++++
 rtl/vlb_chn_join.sv | 107 ++++++++++
 tb/tb_vlb_chn_join.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vlb_chn_join_pkg.sv
// ----------------------------------------------------------------------------
// vlb_chn_join_pkg
//   Shared definitions for the VLB channel join.
//   - TTW response record layout (default widths of the VLB/TTW complex).
//   - Bit positions inside each channel's 2-bit kill request.
// ----------------------------------------------------------------------------
package vlb_chn_join_pkg;

    // Default TTW field widths used across the VLB/TTW complex.
    localparam int VLB_IW = 6;
    localparam int VLB_MW = 52;
    localparam int VLB_AW = 4;

    // Per-channel kill request bit positions.
    localparam int KILL_IMM   = 0;
    localparam int KILL_FLUSH = 1;

    typedef struct packed {
        logic [VLB_IW-1:0] idx;
        logic              vld;
        logic              err;
        logic [VLB_MW-1:0] mpn;
        logic [VLB_AW-1:0] attr;
    } ttw_resp_t;

endpackage

// File: rtl/vlb_chn_join_if.sv
// ----------------------------------------------------------------------------
// vlb_chn_join_if
//   Shared TTW port bundle between the walker side and the channel join.
//   Walker -> join : ttw_i_valid, ttw_i_bits_{idx,vld,err,mpn,attr}, busy_i
//   Join -> chans  : chn_ttw_o_valid[N], chn_busy_o[N] (routed),
//                    ttw_o_bits_{idx,vld,err,mpn,attr} (broadcast)
//   master : walker/testbench side, slave : vlb_chn_join.
// ----------------------------------------------------------------------------
interface vlb_chn_join_if #(
    parameter int N  = 2,
    parameter int IW = 6,
    parameter int MW = 52,
    parameter int AW = 4
);
    logic          ttw_i_valid;
    logic [IW-1:0] ttw_i_bits_idx;
    logic          ttw_i_bits_vld;
    logic          ttw_i_bits_err;
    logic [MW-1:0] ttw_i_bits_mpn;
    logic [AW-1:0] ttw_i_bits_attr;
    logic          busy_i;

    logic [N-1:0]  chn_ttw_o_valid;
    logic [N-1:0]  chn_busy_o;
    logic [IW-1:0] ttw_o_bits_idx;
    logic          ttw_o_bits_vld;
    logic          ttw_o_bits_err;
    logic [MW-1:0] ttw_o_bits_mpn;
    logic [AW-1:0] ttw_o_bits_attr;

    modport master (
        output ttw_i_valid, ttw_i_bits_idx, ttw_i_bits_vld, ttw_i_bits_err,
               ttw_i_bits_mpn, ttw_i_bits_attr, busy_i,
        input  chn_ttw_o_valid, chn_busy_o, ttw_o_bits_idx, ttw_o_bits_vld,
               ttw_o_bits_err, ttw_o_bits_mpn, ttw_o_bits_attr
    );

    modport slave (
        input  ttw_i_valid, ttw_i_bits_idx, ttw_i_bits_vld, ttw_i_bits_err,
               ttw_i_bits_mpn, ttw_i_bits_attr, busy_i,
        output chn_ttw_o_valid, chn_busy_o, ttw_o_bits_idx, ttw_o_bits_vld,
               ttw_o_bits_err, ttw_o_bits_mpn, ttw_o_bits_attr
    );
endinterface

// File: rtl/vlb_kill_barrier.sv
// ----------------------------------------------------------------------------
// vlb_kill_barrier
//   Flush-kill barrier across N channels with an optional watchdog.
//   clock, reset : clock, asynchronous active-high reset
//   en_i[N]      : channel enabled (disabled channels count as ready)
//   flush_i[N]   : flush-kill request per channel
//   fire_o       : combinational barrier fire
//   pend_o[N]    : sticky "already asked" state per channel
//   tmo_o        : one-cycle pulse, the cycle after the watchdog forced a fire
// ----------------------------------------------------------------------------
module vlb_kill_barrier #(
    parameter int N   = 2,
    parameter int TMO = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] en_i,
    input  logic [N-1:0] flush_i,
    output logic         fire_o,
    output logic [N-1:0] pend_o,
    output logic         tmo_o
);
    logic [N-1:0] pend_q, pend_d;
    logic [N-1:0] rdy;
    logic         any_req;
    logic         fire_nat;
    logic         wdog_force;
    logic         fire;

    assign rdy      = flush_i | pend_q | ~en_i;
    assign any_req  = |(flush_i | pend_q);
    // At least one real request is needed, so an all-disabled idle join never fires.
    assign fire_nat = (&rdy) & any_req;
    assign fire     = fire_nat | wdog_force;

    // A request arriving together with fire is consumed by it, not re-armed.
    assign pend_d = fire ? '0 : (pend_q | flush_i);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    if (TMO > 0) begin : g_wdog
        localparam int TW = $clog2(TMO + 1);
        logic [TW-1:0] tmr_q, tmr_d;
        logic          cnt_en;
        logic          tmo_q;

        // Count on the natural fire only; using fire here would loop through force.
        assign cnt_en     = (|pend_q) & ~fire_nat;
        assign wdog_force = cnt_en & (tmr_q == TW'(TMO - 1));

        always_comb begin
            tmr_d = tmr_q;
            if (fire || !(|pend_q)) begin
                tmr_d = '0;
            end else if (cnt_en && (tmr_q != TW'(TMO))) begin
                tmr_d = tmr_q + 1'b1;
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                tmr_q <= '0;
                tmo_q <= 1'b0;
            end else begin
                tmr_q <= tmr_d;
                tmo_q <= wdog_force;
            end
        end

        assign tmo_o = tmo_q;
    end else begin : g_no_wdog
        assign wdog_force = 1'b0;
        assign tmo_o      = 1'b0;
    end

    assign fire_o = fire;
    assign pend_o = pend_q;

endmodule

// File: rtl/vlb_chn_join.sv
// ----------------------------------------------------------------------------
// vlb_chn_join
//   Joins N VLB requester channels onto one shared TTW port.
//   clock, reset         : clock, asynchronous active-high reset
//   chn_en_i[N]          : channel enabled (barrier only; routing ignores it)
//   chn_kill_i[N][2]     : [0] immediate kill, [1] flush-kill request
//   chn_req_valid_i[N]   : channel request valid
//   chn_req_idx_i[N][IW] : channel request index
//   chn_req_valid_q_o    : request valid delayed one cycle
//   chn_req_idx_q_o      : request index delayed one cycle
//   ttw                  : shared TTW response in, routed valid/busy and
//                          broadcast response fields out
//   kill_o[3]            : {fire, fire, immediate} to the walker
//   tmo_o                : watchdog forced-fire pulse
//   pend_o[N]            : barrier sticky state
// ----------------------------------------------------------------------------
module vlb_chn_join
    import vlb_chn_join_pkg::*;
#(
    parameter int N   = 2,
    parameter int IW  = 6,
    parameter int MW  = 52,
    parameter int AW  = 4,
    parameter int TMO = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         chn_en_i,
    input  logic [N-1:0][1:0]    chn_kill_i,
    input  logic [N-1:0]         chn_req_valid_i,
    input  logic [N-1:0][IW-1:0] chn_req_idx_i,
    output logic [N-1:0]         chn_req_valid_q_o,
    output logic [N-1:0][IW-1:0] chn_req_idx_q_o,
    vlb_chn_join_if.slave        ttw,
    output logic [2:0]           kill_o,
    output logic                 tmo_o,
    output logic [N-1:0]         pend_o
);
    localparam int CW = $clog2(N);

    logic [IW-1:0] rsp_idx;
    logic [MW-1:0] rsp_mpn;
    logic [AW-1:0] rsp_attr;
    logic [CW-1:0] sel;
    logic [N-1:0]  rsp_vld;
    logic [N-1:0]  rsp_busy;
    logic [N-1:0]  kill_imm;
    logic [N-1:0]  kill_flush;
    logic          fire;

    assign rsp_idx  = ttw.ttw_i_bits_idx;
    assign rsp_mpn  = ttw.ttw_i_bits_mpn;
    assign rsp_attr = ttw.ttw_i_bits_attr;

    // Owning channel lives in the top index bits.
    assign sel = rsp_idx[IW-1 -: CW];

    for (genvar c = 0; c < N; c++) begin : g_chn
        logic          req_vld_q, req_vld_d;
        logic [IW-1:0] req_idx_q, req_idx_d;

        assign rsp_vld[c]    = ttw.ttw_i_valid & (sel == CW'(c));
        assign rsp_busy[c]   = ttw.busy_i & (sel == CW'(c));
        assign kill_imm[c]   = chn_kill_i[c][KILL_IMM];
        assign kill_flush[c] = chn_kill_i[c][KILL_FLUSH];

        assign req_vld_d = chn_req_valid_i[c];
        assign req_idx_d = chn_req_idx_i[c];

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                req_vld_q <= 1'b0;
                req_idx_q <= '0;
            end else begin
                req_vld_q <= req_vld_d;
                req_idx_q <= req_idx_d;
            end
        end

        assign chn_req_valid_q_o[c] = req_vld_q;
        assign chn_req_idx_q_o[c]   = req_idx_q;
    end

    assign ttw.chn_ttw_o_valid = rsp_vld;
    assign ttw.chn_busy_o      = rsp_busy;
    assign ttw.ttw_o_bits_idx  = rsp_idx;
    assign ttw.ttw_o_bits_vld  = ttw.ttw_i_bits_vld;
    assign ttw.ttw_o_bits_err  = ttw.ttw_i_bits_err;
    assign ttw.ttw_o_bits_mpn  = rsp_mpn;
    assign ttw.ttw_o_bits_attr = rsp_attr;

    vlb_kill_barrier #(
        .N   (N),
        .TMO (TMO)
    ) u_barrier (
        .clock   (clock),
        .reset   (reset),
        .en_i    (chn_en_i),
        .flush_i (kill_flush),
        .fire_o  (fire),
        .pend_o  (pend_o),
        .tmo_o   (tmo_o)
    );

    assign kill_o = {fire, fire, |kill_imm};

endmodule

// File: tb/tb_vlb_chn_join.sv
// ----------------------------------------------------------------------------
// tb_vlb_chn_join
//   Three joins: d0 (N=2, IW=6, no watchdog), d1 (same inputs as d0,
//   watchdog TMO=8) and d2 (N=4, IW=7). A set-based barrier model and an
//   arithmetic routing model supply every expected value.
// ----------------------------------------------------------------------------
module tb_vlb_chn_join;
    import vlb_chn_join_pkg::*;

    localparam int WD_TMO = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // d0 / d1 channel side
    logic [1:0]       en_a;
    logic [1:0][1:0]  kill_a;
    logic [1:0]       rv_a;
    logic [1:0][5:0]  ri_a;
    logic [1:0]       rvq0, rvq1;
    logic [1:0][5:0]  riq0, riq1;
    logic [2:0]       kill0, kill1;
    logic             tmo0, tmo1;
    logic [1:0]       pend0, pend1;
    // d2 channel side
    logic [3:0]       en_b;
    logic [3:0][1:0]  kill_b;
    logic [3:0]       rv_b;
    logic [3:0][6:0]  ri_b;
    logic [3:0]       rvq2;
    logic [3:0][6:0]  riq2;
    logic [2:0]       kill2;
    logic             tmo2;
    logic [3:0]       pend2;

    vlb_chn_join_if #(.N(2), .IW(6), .MW(52), .AW(4)) if0 ();
    vlb_chn_join_if #(.N(2), .IW(6), .MW(52), .AW(4)) if1 ();
    vlb_chn_join_if #(.N(4), .IW(7), .MW(52), .AW(4)) if2 ();

    assign if1.ttw_i_valid     = if0.ttw_i_valid;
    assign if1.ttw_i_bits_idx  = if0.ttw_i_bits_idx;
    assign if1.ttw_i_bits_vld  = if0.ttw_i_bits_vld;
    assign if1.ttw_i_bits_err  = if0.ttw_i_bits_err;
    assign if1.ttw_i_bits_mpn  = if0.ttw_i_bits_mpn;
    assign if1.ttw_i_bits_attr = if0.ttw_i_bits_attr;
    assign if1.busy_i          = if0.busy_i;

    vlb_chn_join #(.N(2), .IW(6), .MW(52), .AW(4), .TMO(0)) d0 (
        .clock(clock), .reset(reset), .chn_en_i(en_a), .chn_kill_i(kill_a),
        .chn_req_valid_i(rv_a), .chn_req_idx_i(ri_a),
        .chn_req_valid_q_o(rvq0), .chn_req_idx_q_o(riq0), .ttw(if0),
        .kill_o(kill0), .tmo_o(tmo0), .pend_o(pend0));

    vlb_chn_join #(.N(2), .IW(6), .MW(52), .AW(4), .TMO(WD_TMO)) d1 (
        .clock(clock), .reset(reset), .chn_en_i(en_a), .chn_kill_i(kill_a),
        .chn_req_valid_i(rv_a), .chn_req_idx_i(ri_a),
        .chn_req_valid_q_o(rvq1), .chn_req_idx_q_o(riq1), .ttw(if1),
        .kill_o(kill1), .tmo_o(tmo1), .pend_o(pend1));

    vlb_chn_join #(.N(4), .IW(7), .MW(52), .AW(4), .TMO(0)) d2 (
        .clock(clock), .reset(reset), .chn_en_i(en_b), .chn_kill_i(kill_b),
        .chn_req_valid_i(rv_b), .chn_req_idx_i(ri_b),
        .chn_req_valid_q_o(rvq2), .chn_req_idx_q_o(riq2), .ttw(if2),
        .kill_o(kill2), .tmo_o(tmo2), .pend_o(pend2));

    // Reference state: which channels have asked, and how long d1 has waited.
    logic [3:0] mp0, mp1, mp2;
    int         a1;
    logic       et1;
    // Response stimulus as driven.
    ttw_resp_t  rsp0;
    logic       v0, b0;
    logic [6:0] idx2;
    logic [3:0] attr2;
    logic       v2, b2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Barrier fires when every channel is ready and at least one has asked.
    function automatic logic fire_of(input int n, input logic [3:0] en,
                                     input logic [3:0] fl, input logic [3:0] pend);
        int asked = 0;
        int ready = 0;
        for (int i = 0; i < n; i++) begin
            if (fl[i] || pend[i]) asked++;
            if (fl[i] || pend[i] || !en[i]) ready++;
        end
        return (asked > 0) && (ready == n);
    endfunction

    // One-hot owner from the top index bits; both configurations use idx/32.
    function automatic logic [3:0] exp_route(input logic v, input int idx);
        return v ? 4'(1 << (idx / 32)) : 4'b0000;
    endfunction

    task automatic drive_rsp0(input ttw_resp_t r, input logic v, input logic b);
        rsp0 = r; v0 = v; b0 = b;
        if0.ttw_i_valid     = v;
        if0.ttw_i_bits_idx  = r.idx;
        if0.ttw_i_bits_vld  = r.vld;
        if0.ttw_i_bits_err  = r.err;
        if0.ttw_i_bits_mpn  = r.mpn;
        if0.ttw_i_bits_attr = r.attr;
        if0.busy_i          = b;
    endtask

    task automatic drive_rsp2(input logic [6:0] idx, input logic [3:0] attr,
                              input logic v, input logic b);
        idx2 = idx; attr2 = attr; v2 = v; b2 = b;
        if2.ttw_i_valid     = v;
        if2.ttw_i_bits_idx  = idx;
        if2.ttw_i_bits_vld  = 1'b1;
        if2.ttw_i_bits_err  = 1'b0;
        if2.ttw_i_bits_mpn  = 52'($urandom);
        if2.ttw_i_bits_attr = attr;
        if2.busy_i          = b;
    endtask

    task automatic drv_kill_a(input logic [1:0] fl, input logic [1:0] im);
        kill_a[0] = {fl[0], im[0]};
        kill_a[1] = {fl[1], im[1]};
    endtask

    // One clock: check combinational outputs and current state, advance the
    // model across the edge, then check the registered outputs.
    task automatic step();
        logic [3:0] fl0, fl2;
        logic im0, im2, f0, f1, f2, nat1, frc1;
        logic [1:0] s_rv0;
        logic [1:0][5:0] s_ri0;
        logic [3:0] s_rv2;
        logic [3:0][6:0] s_ri2;
        #2;
        fl0 = {2'b00, kill_a[1][KILL_FLUSH], kill_a[0][KILL_FLUSH]};
        im0 = kill_a[1][KILL_IMM] | kill_a[0][KILL_IMM];
        fl2 = '0;
        im2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fl2[i] = kill_b[i][KILL_FLUSH];
            im2    = im2 | kill_b[i][KILL_IMM];
        end
        f0   = fire_of(2, {2'b00, en_a}, fl0, mp0);
        nat1 = fire_of(2, {2'b00, en_a}, fl0, mp1);
        frc1 = (mp1 != 4'b0) && !nat1 && (a1 == WD_TMO - 1);
        f1   = nat1 | frc1;
        f2   = fire_of(4, en_b, fl2, mp2);

        chk("kill_d0", 64'(kill0), 64'({f0, f0, im0}));
        chk("kill_d1", 64'(kill1), 64'({f1, f1, im0}));
        chk("kill_d2", 64'(kill2), 64'({f2, f2, im2}));
        chk("pend_d0", 64'(pend0), 64'(mp0));
        chk("pend_d1", 64'(pend1), 64'(mp1));
        chk("pend_d2", 64'(pend2), 64'(mp2));
        chk("tmo_d0", 64'(tmo0), 64'd0);
        chk("tmo_d1", 64'(tmo1), 64'(et1));
        chk("tmo_d2", 64'(tmo2), 64'd0);
        chk("route_vld_d0", 64'(if0.chn_ttw_o_valid), 64'(exp_route(v0, int'(rsp0.idx))));
        chk("route_busy_d0", 64'(if0.chn_busy_o), 64'(exp_route(b0, int'(rsp0.idx))));
        chk("route_vld_d1", 64'(if1.chn_ttw_o_valid), 64'(exp_route(v0, int'(rsp0.idx))));
        chk("bcast_d0", 64'({if0.ttw_o_bits_idx, if0.ttw_o_bits_vld, if0.ttw_o_bits_err,
                             if0.ttw_o_bits_mpn, if0.ttw_o_bits_attr}), 64'(rsp0));
        chk("route_vld_d2", 64'(if2.chn_ttw_o_valid), 64'(exp_route(v2, int'(idx2))));
        chk("route_busy_d2", 64'(if2.chn_busy_o), 64'(exp_route(b2, int'(idx2))));
        chk("bcast_d2", 64'({if2.ttw_o_bits_idx, if2.ttw_o_bits_attr}), 64'({idx2, attr2}));

        s_rv0 = rv_a; s_ri0 = ri_a; s_rv2 = rv_b; s_ri2 = ri_b;
        @(posedge clock);
        #1;
        if (reset) begin
            mp0 = '0; mp1 = '0; mp2 = '0; a1 = 0; et1 = 1'b0;
            chk("reqq_rst_d0", 64'({rvq0, riq0}), 64'd0);
            chk("reqq_rst_d2", 64'({rvq2, riq2}), 64'd0);
        end else begin
            a1  = (f1 || mp1 == 4'b0) ? 0 : a1 + 1;
            et1 = frc1;
            mp0 = f0 ? 4'b0 : (mp0 | fl0);
            mp1 = f1 ? 4'b0 : (mp1 | fl0);
            mp2 = f2 ? 4'b0 : (mp2 | fl2);
            chk("reqq_d0", 64'({rvq0, riq0}), 64'({s_rv0, s_ri0}));
            chk("reqq_d1", 64'({rvq1, riq1}), 64'({s_rv0, s_ri0}));
            chk("reqq_d2", 64'({rvq2, riq2}), 64'({s_rv2, s_ri2}));
        end
    endtask

    // ch0 asks once on d1 while ch1 stays silent: pend_o must stay high for
    // TMO cycles, the last of which carries the forced fire.
    task automatic wdog_run(input string tag);
        int   n;
        logic seen;
        drv_kill_a(2'b01, 2'b00);
        step();
        drv_kill_a(2'b00, 2'b00);
        n = 0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            n++;
            seen = kill1[2];
            step();
            if (seen) break;
        end
        chk({tag, "_seen"}, 64'(seen), 64'd1);
        chk({tag, "_len"}, 64'(n), 64'(WD_TMO));
        chk({tag, "_d0_pend"}, 64'(pend0), 64'b01);
        #1;
        chk({tag, "_tmo_pulse"}, 64'(tmo1), 64'd1);
        chk({tag, "_pend_clr"}, 64'(pend1), 64'd0);
        step();
        #1;
        chk({tag, "_tmo_end"}, 64'(tmo1), 64'd0);
    endtask

    initial begin
        ttw_resp_t r;
        reset = 1'b1;
        mp0 = '0; mp1 = '0; mp2 = '0; a1 = 0; et1 = 1'b0;
        en_a = 2'b11; kill_a = '0; rv_a = '0; ri_a = '0;
        en_b = 4'hF;  kill_b = '0; rv_b = '0; ri_b = '0;
        drive_rsp0('0, 1'b0, 1'b0);
        drive_rsp2('0, '0, 1'b0, 1'b0);
        #1;
        chk("rst_pend", 64'({pend0, pend1, pend2}), 64'd0);
        chk("rst_tmo", 64'({tmo0, tmo1, tmo2}), 64'd0);
        chk("rst_reqq", 64'({rvq0, riq0, rvq2, riq2}), 64'd0);
        // Combinational fire still follows requests while in reset.
        drv_kill_a(2'b11, 2'b00);
        #1;
        chk("rst_comb_fire", 64'(kill0), 64'b110);
        step();
        drv_kill_a(2'b00, 2'b00);
        step();
        reset = 1'b0;
        step();

        // Routing
        r = '0;
        r.idx = 6'h25; r.mpn = 52'hABCDE12345678; r.attr = 4'h9;
        drive_rsp0(r, 1'b1, 1'b0);
        #1;
        chk("route_0x25", 64'(if0.chn_ttw_o_valid), 64'b10);
        r.idx = 6'h05;
        drive_rsp0(r, 1'b0, 1'b1);
        #1;
        chk("busy_0x05", 64'(if0.chn_busy_o), 64'b01);
        step();

        // Staggered flush
        drv_kill_a(2'b01, 2'b00);
        step();
        drv_kill_a(2'b00, 2'b00);
        #1;
        chk("stag_pend_c1", 64'(pend0), 64'b01);
        step();
        step();
        drv_kill_a(2'b10, 2'b00);
        #1;
        chk("stag_fire_c3", 64'(kill0), 64'b110);
        step();
        drv_kill_a(2'b00, 2'b00);
        #1;
        chk("stag_pend_c4", 64'(pend0), 64'b00);
        chk("stag_kill_c4", 64'(kill0), 64'b000);
        step();

        // Simultaneous, single enabled channel, all disabled
        drv_kill_a(2'b11, 2'b00);
        #1;
        chk("simul_fire", 64'(kill0), 64'b110);
        step();
        drv_kill_a(2'b00, 2'b00);
        #1;
        chk("simul_pend", 64'(pend0), 64'b00);
        en_a = 2'b01;
        drv_kill_a(2'b01, 2'b00);
        #1;
        chk("en01_fire", 64'(kill0), 64'b110);
        step();
        drv_kill_a(2'b00, 2'b00);
        en_a = 2'b00;
        #1;
        chk("en00_idle", 64'(kill0), 64'b000);
        step();
        step();
        en_a = 2'b11;
        step();

        // N=4 routing and immediate kill
        drive_rsp2(7'h60, 4'h3, 1'b1, 1'b0);
        kill_b[2] = 2'b01;
        #1;
        chk("d2_route_0x60", 64'(if2.chn_ttw_o_valid), 64'b1000);
        chk("d2_imm_kill", 64'(kill2[0]), 64'd1);
        step();
        kill_b = '0;
        step();

        // Watchdog
        wdog_run("wdog1");

        // Asynchronous reset mid-barrier
        drv_kill_a(2'b01, 2'b00);
        step();
        drv_kill_a(2'b00, 2'b00);
        step();
        #3;
        reset = 1'b1;
        #1;
        chk("arst_pend", 64'({pend0, pend1}), 64'd0);
        chk("arst_kill", 64'({kill0, kill1}), 64'd0);
        chk("arst_tmo", 64'(tmo1), 64'd0);
        mp0 = '0; mp1 = '0; mp2 = '0; a1 = 0; et1 = 1'b0;
        @(posedge clock);
        #1;
        chk("arst_reqq", 64'({rvq0, riq0}), 64'd0);
        reset = 1'b0;
        step();
        wdog_run("wdog2");

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            r = ttw_resp_t'({$urandom(), $urandom()});
            drive_rsp0(r, 1'($urandom), 1'($urandom));
            drive_rsp2(7'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
            en_a = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11;
            en_b = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            for (int i = 0; i < 2; i++)
                kill_a[i] = {($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0)};
            for (int i = 0; i < 4; i++)
                kill_b[i] = {($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0)};
            rv_a = 2'($urandom);
            ri_a = 12'($urandom);
            rv_b = 4'($urandom);
            ri_b = 28'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
